// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
//   Host-facing command responder behind a UART byte interface. It parses framed commands from the
//   RX side, issues one 32-bit read or write on a valid/ready memory bus, and sends the reply bytes
//   back through the TX side. This is the debug/load path into SoC memory.
//
//   Frames (multi-byte fields MSB first):
//     write : 0x57 A3 A2 A1 A0 D3 D2 D1 D0  -> reply 0x4B
//     read  : 0x52 A3 A2 A1 A0              -> reply D3 D2 D1 D0
//     other first byte                      -> reply 0x45, no bus access
//     bus timeout                           -> reply 0x45
//
// Parameters
//   TIMEOUT_CYCLES  inter-byte idle limit inside a frame; on expiry the frame is dropped silently
//   BUS_TIMEOUT     max cycles o_mem_valid is held without i_mem_ready before an error reply
//
// Ports
//   i_clk                   clock
//   i_rst                   synchronous reset, active-high
//   i_uart_received         one-cycle strobe, i_uart_rx_byte valid
//   i_uart_rx_byte[7:0]     received byte
//   i_uart_recv_error       UART framing error strobe
//   o_uart_transmit         one-cycle request to send o_uart_tx_byte
//   o_uart_tx_byte[7:0]     byte to send, stable while o_uart_transmit=1
//   i_uart_is_transmitting  UART TX busy
//   o_mem_valid             bus request
//   i_mem_ready             bus completion (transfer when valid & ready)
//   o_mem_addr[31:0]        byte address, passed unmodified
//   o_mem_wdata[31:0]       write data
//   o_mem_wstrb[3:0]        4'hF for write, 4'h0 for read
//   i_mem_rdata[31:0]       read data, sampled on the transfer cycle
//   o_busy                  high whenever the bridge is not idle

module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned BUS_TIMEOUT    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_uart_received,
  input  logic [7:0]  i_uart_rx_byte,
  input  logic        i_uart_recv_error,
  output logic        o_uart_transmit,
  output logic [7:0]  o_uart_tx_byte,
  input  logic        i_uart_is_transmitting,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  // Counters only ever need to reach LIMIT-1: the expiry decision is taken on that cycle.
  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BusW  = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [BusW-1:0]  BusLast  = BusW'(BUS_TIMEOUT - 1);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RespAck  = 8'h4B;
  localparam logic [7:0] RespErr  = 8'h45;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StBus,
    StResp,
    StTxGap
  } state_e;

  state_e           r_state;
  logic             r_is_write;
  logic [1:0]       r_byte_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [IdleW-1:0] r_idle_cnt;
  logic [BusW-1:0]  r_bus_cnt;
  logic [31:0]      r_resp_sr;
  logic [2:0]       r_resp_cnt;
  logic             r_tx;
  logic [7:0]       r_tx_byte;

  state_e           w_state_d;
  logic             w_is_write_d;
  logic [1:0]       w_byte_cnt_d;
  logic [31:0]      w_addr_d;
  logic [31:0]      w_wdata_d;
  logic [IdleW-1:0] w_idle_cnt_d;
  logic [BusW-1:0]  w_bus_cnt_d;
  logic [31:0]      w_resp_sr_d;
  logic [2:0]       w_resp_cnt_d;
  logic             w_tx_d;
  logic [7:0]       w_tx_byte_d;

  // A byte flagged with a framing error is never treated as data.
  logic w_rx_ok;
  assign w_rx_ok = i_uart_received & ~i_uart_recv_error;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_is_write <= 1'b0;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_idle_cnt <= '0;
      r_bus_cnt  <= '0;
      r_resp_sr  <= '0;
      r_resp_cnt <= '0;
      r_tx       <= 1'b0;
      r_tx_byte  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_is_write <= w_is_write_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_bus_cnt  <= w_bus_cnt_d;
      r_resp_sr  <= w_resp_sr_d;
      r_resp_cnt <= w_resp_cnt_d;
      r_tx       <= w_tx_d;
      r_tx_byte  <= w_tx_byte_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_is_write_d = r_is_write;
    w_byte_cnt_d = r_byte_cnt;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_idle_cnt_d = r_idle_cnt;
    w_bus_cnt_d  = '0;
    w_resp_sr_d  = r_resp_sr;
    w_resp_cnt_d = r_resp_cnt;
    w_tx_d       = 1'b0;
    w_tx_byte_d  = r_tx_byte;

    unique case (r_state)
      StIdle: begin
        if (w_rx_ok) begin
          w_byte_cnt_d = '0;
          w_idle_cnt_d = '0;
          if (i_uart_rx_byte == CmdWrite) begin
            w_is_write_d = 1'b1;
            w_state_d    = StAddr;
          end else if (i_uart_rx_byte == CmdRead) begin
            w_is_write_d = 1'b0;
            w_state_d    = StAddr;
          end else begin
            w_resp_sr_d  = {RespErr, 24'h0};
            w_resp_cnt_d = 3'd1;
            w_state_d    = StResp;
          end
        end
      end

      StAddr, StWdata: begin
        if (i_uart_recv_error) begin
          w_state_d = StIdle;
        end else if (i_uart_received) begin
          w_idle_cnt_d = '0;
          w_byte_cnt_d = r_byte_cnt + 2'd1;
          if (r_state == StAddr) begin
            w_addr_d = {r_addr[23:0], i_uart_rx_byte};
          end else begin
            w_wdata_d = {r_wdata[23:0], i_uart_rx_byte};
          end
          if (r_byte_cnt == 2'd3) begin
            // Byte count wraps to 0, ready for the data field of a write.
            if (r_state == StAddr && r_is_write) begin
              w_state_d = StWdata;
            end else begin
              w_state_d = StBus;
            end
          end
        end else if (r_idle_cnt >= IdleLast) begin
          w_state_d = StIdle;
        end else begin
          w_idle_cnt_d = r_idle_cnt + IdleW'(1);
        end
      end

      StBus: begin
        // A transfer on the final allowed cycle beats the timeout.
        if (i_mem_ready) begin
          if (r_is_write) begin
            w_resp_sr_d  = {RespAck, 24'h0};
            w_resp_cnt_d = 3'd1;
          end else begin
            w_resp_sr_d  = i_mem_rdata;
            w_resp_cnt_d = 3'd4;
          end
          w_state_d = StResp;
        end else if (r_bus_cnt >= BusLast) begin
          w_resp_sr_d  = {RespErr, 24'h0};
          w_resp_cnt_d = 3'd1;
          w_state_d    = StResp;
        end else begin
          w_bus_cnt_d = r_bus_cnt + BusW'(1);
        end
      end

      StResp: begin
        if (!i_uart_is_transmitting) begin
          w_tx_d       = 1'b1;
          w_tx_byte_d  = r_resp_sr[31:24];
          w_resp_sr_d  = {r_resp_sr[23:0], 8'h0};
          w_resp_cnt_d = r_resp_cnt - 3'd1;
          w_state_d    = StTxGap;
        end
      end

      StTxGap: begin
        // The UART busy flag reflects our request only one cycle later; wait it out here.
        w_state_d = (r_resp_cnt != 3'd0) ? StResp : StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_uart_transmit = r_tx;
  assign o_uart_tx_byte  = r_tx_byte;
  assign o_mem_valid     = (r_state == StBus);
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;
  assign o_mem_wstrb     = {4{r_is_write}};
  assign o_busy          = (r_state != StIdle);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
module tb_uart_cmd_bridge;

  localparam int unsigned TO  = 200;
  localparam int unsigned BT  = 40;
  localparam int          TXB = 4;

  logic        clk;
  logic        i_rst;
  logic        i_uart_received;
  logic [7:0]  i_uart_rx_byte;
  logic        i_uart_recv_error;
  logic        o_uart_transmit;
  logic [7:0]  o_uart_tx_byte;
  logic        i_uart_is_transmitting;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  uart_cmd_bridge #(
    .TIMEOUT_CYCLES(TO),
    .BUS_TIMEOUT   (BT)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (i_rst),
    .i_uart_received       (i_uart_received),
    .i_uart_rx_byte        (i_uart_rx_byte),
    .i_uart_recv_error     (i_uart_recv_error),
    .o_uart_transmit       (o_uart_transmit),
    .o_uart_tx_byte        (o_uart_tx_byte),
    .i_uart_is_transmitting(i_uart_is_transmitting),
    .o_mem_valid           (o_mem_valid),
    .i_mem_ready           (i_mem_ready),
    .o_mem_addr            (o_mem_addr),
    .o_mem_wdata           (o_mem_wdata),
    .o_mem_wstrb           (o_mem_wstrb),
    .i_mem_rdata           (i_mem_rdata),
    .o_busy                (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: ready after ready_delay cycles of valid; negative delay never answers.
  int ready_delay = 0;
  int vcnt = 0;
  always @(posedge clk) begin
    if (i_rst || !o_mem_valid || i_mem_ready) vcnt <= 0;
    else vcnt <= vcnt + 1;
  end
  assign i_mem_ready = o_mem_valid && (ready_delay >= 0) && (vcnt == ready_delay);

  // UART TX peer: busy for TXB cycles starting the cycle after a request.
  int tx_busy_cnt = 0;
  always @(posedge clk) begin
    if (i_rst) tx_busy_cnt <= 0;
    else if (o_uart_transmit) tx_busy_cnt <= TXB;
    else if (tx_busy_cnt > 0) tx_busy_cnt <= tx_busy_cnt - 1;
  end
  assign i_uart_is_transmitting = (tx_busy_cnt != 0);

  // Monitors, sampled on the falling edge.
  logic [31:0] bus_addr_q[$];
  logic [31:0] bus_wdata_q[$];
  logic [3:0]  bus_wstrb_q[$];
  logic [7:0]  tx_q[$];
  int vrun = 0;
  int last_vlen = 0;
  int tx_wide = 0;
  int tx_overlap = 0;
  logic tx_prev = 1'b0;

  always @(negedge clk) begin
    if (o_mem_valid) begin
      vrun <= vrun + 1;
      if (i_mem_ready) begin
        bus_addr_q.push_back(o_mem_addr);
        bus_wdata_q.push_back(o_mem_wdata);
        bus_wstrb_q.push_back(o_mem_wstrb);
      end
    end else if (vrun != 0) begin
      last_vlen <= vrun;
      vrun <= 0;
    end
    if (o_uart_transmit) begin
      tx_q.push_back(o_uart_tx_byte);
      if (tx_prev) tx_wide <= tx_wide + 1;
      if (i_uart_is_transmitting) tx_overlap <= tx_overlap + 1;
    end
    tx_prev <= o_uart_transmit;
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_uart_rx_byte  = b;
    i_uart_received = 1'b1;
    @(posedge clk);
    #1;
    i_uart_received = 1'b0;
  endtask

  task automatic clear_mon();
    bus_addr_q.delete();
    bus_wdata_q.delete();
    bus_wstrb_q.delete();
    tx_q.delete();
    last_vlen = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, o_busy, 0);
  endtask

  // kind: 0 write, 1 read, 2 bad command byte 'bad'. stray: 0x41 bytes sent while the bus is busy.
  task automatic run_txn(input string tag, input int kind, input logic [7:0] bad,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int delay, input int stray);
    logic [7:0] fr[$];
    logic [7:0] exp_tx[$];
    int exp_bus;
    int exp_vlen;
    clear_mon();
    i_mem_rdata = rdata;
    ready_delay = delay;
    if (kind == 0) fr.push_back(8'h57);
    else if (kind == 1) fr.push_back(8'h52);
    else fr.push_back(bad);
    if (kind < 2) for (int i = 3; i >= 0; i--) fr.push_back(addr[8*i +: 8]);
    if (kind == 0) for (int i = 3; i >= 0; i--) fr.push_back(data[8*i +: 8]);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (i != fr.size() - 1) tick($urandom_range(0, 2));
    end
    if (kind < 2) check({tag, "_valid_latency"}, o_mem_valid, 1);
    for (int i = 0; i < stray; i++) begin
      tick(3);
      send_byte(8'h41);
    end
    wait_idle(tag, 400);

    // Expected outcome from the frame rules.
    if (kind == 2) begin
      exp_bus  = 0;
      exp_vlen = 0;
      exp_tx.push_back(8'h45);
    end else if (delay < 0 || delay >= int'(BT)) begin
      exp_bus  = 0;
      exp_vlen = BT;
      exp_tx.push_back(8'h45);
    end else begin
      exp_bus  = 1;
      exp_vlen = delay + 1;
      if (kind == 0) exp_tx.push_back(8'h4B);
      else for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[8*i +: 8]);
    end

    check({tag, "_bus_count"}, bus_addr_q.size(), exp_bus);
    check({tag, "_valid_len"}, last_vlen, exp_vlen);
    if (exp_bus == 1 && bus_addr_q.size() == 1) begin
      check({tag, "_addr"}, bus_addr_q[0], addr);
      check({tag, "_wstrb"}, bus_wstrb_q[0], (kind == 0) ? 4'hF : 4'h0);
      if (kind == 0) check({tag, "_wdata"}, bus_wdata_q[0], data);
    end
    check({tag, "_tx_count"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), tx_q[i], exp_tx[i]);
  endtask

  initial begin
    int kind;
    int n;
    logic [7:0] bad;
    i_rst             = 1'b1;
    i_uart_received   = 1'b0;
    i_uart_rx_byte    = 8'h00;
    i_uart_recv_error = 1'b0;
    i_mem_rdata       = 32'h0;
    tick(3);
    i_rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {o_uart_transmit, o_uart_tx_byte, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_wstrb,
           o_busy}, 0);

    // Write, ready after 3 cycles.
    run_txn("t1_write", 0, 8'h00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3, 0);
    // Read returning 0x12345678.
    run_txn("t2_read", 1, 8'h00, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0);
    // Unknown command, then a normal read.
    run_txn("t3_bad", 2, 8'h41, 32'h0, 32'h0, 32'h0, 0, 0);
    run_txn("t3_read", 1, 8'h00, 32'hCAFE_0004, 32'h0, 32'h0BAD_F00D, 2, 0);

    // Inter-byte timeout.
    clear_mon();
    send_byte(8'h57);
    tick(1);
    send_byte(8'h00);
    tick(TO / 2);
    check("t4_busy_before_timeout", o_busy, 1);
    tick(TO / 2 + 5);
    check("t4_idle_after_timeout", o_busy, 0);
    // Framing error mid-address.
    send_byte(8'h52);
    send_byte(8'h00);
    i_uart_recv_error = 1'b1;
    tick(1);
    i_uart_recv_error = 1'b0;
    tick(1);
    check("t4_idle_after_recv_error", o_busy, 0);
    // Error and byte in the same cycle: error wins.
    send_byte(8'h57);
    i_uart_recv_error = 1'b1;
    send_byte(8'h00);
    i_uart_recv_error = 1'b0;
    tick(1);
    check("t4_idle_error_wins", o_busy, 0);
    tick(10);
    check("t4_no_tx", tx_q.size(), 0);
    check("t4_no_bus", last_vlen, 0);
    run_txn("t4_recover", 1, 8'h00, 32'h8000_0010, 32'h0, 32'hA5A5_5A5A, 1, 0);

    // Bus timeout with stray bytes arriving meanwhile; ready on the last allowed cycle.
    run_txn("t5_timeout", 1, 8'h00, 32'h0000_2000, 32'h0, 32'h1111_2222, -1, 3);
    run_txn("t5_last_cycle", 0, 8'h00, 32'h0000_2004, 32'h7777_8888, 32'h0, BT - 1, 0);
    run_txn("t5_one_late", 1, 8'h00, 32'h0000_2008, 32'h0, 32'h3333_4444, BT, 0);

    // Randomized frames.
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      bad  = 8'($urandom_range(0, 255));
      while (bad == 8'h57 || bad == 8'h52) bad = 8'($urandom_range(0, 255));
      run_txn($sformatf("rnd%0d", it), kind, bad, $urandom, $urandom, $urandom,
              $urandom_range(0, 5), 0);
    end

    // Reset while a read reply is in progress.
    clear_mon();
    i_mem_rdata = 32'hAABB_CCDD;
    ready_delay = 1;
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    n = 0;
    while (tx_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_tx_seen", tx_q.size(), 1);
    if (tx_q.size() > 0) check("t6_first_tx_byte", tx_q[0], 8'hAA);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_outputs_after_reset",
          {o_uart_transmit, o_uart_tx_byte, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_wstrb,
           o_busy}, 0);
    i_rst = 1'b0;
    tick(30);
    check("t6_no_further_tx", tx_q.size(), 1);
    check("t6_idle", o_busy, 0);

    check("tx_single_cycle_pulses", tx_wide, 0);
    check("tx_never_while_busy", tx_overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
